// File: rtl/imm_extend_unit.sv
// ----------------------------------------------------------------------------
// imm_extend_unit
//
// Pipelined immediate generator. It takes a raw immediate field whose valid
// length (1..IN_W bits) is chosen per request and produces an OUT_W-bit
// operand in one of four modes:
//   00 SIGN  : sign-extend from bit L-1
//   01 ZERO  : zero-extend
//   10 SHIFT : sign-extend, then shift left by SHAMT (branch/jump offsets)
//   11 UPPER : place the field in the top L bits, zeros below (LUI-style)
// An illegal length (0 or > IN_W) is replaced by L = IN_W. The data is still
// produced, and the result is flagged with err = 1.
//
// Results are computed combinationally at the input and written into a
// 2-entry output FIFO, so a stalled consumer never loses an immediate.
//
// Handshake (both sides): a transfer happens on a rising clk edge where
// valid & ready are both high. in_ready depends only on the registered
// entry count, so there is no combinational path from out_ready to in_ready.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   request valid
//   in_ready   out  unit can accept a request this cycle (count != 2)
//   in_imm     in   [IN_W-1:0]  raw field; bits at and above in_len ignored
//   in_len     in   [LEN_W-1:0] number of valid field bits
//   in_mode    in   [1:0]       extension mode (see above)
//   out_valid  out  head entry is valid (count != 0)
//   out_ready  in   consumer takes the head entry this cycle
//   out_data   out  [OUT_W-1:0] extended immediate (0 when empty)
//   out_err    out  illegal in_len for this result (0 when empty)
// ----------------------------------------------------------------------------
module imm_extend_unit #(
    parameter int IN_W  = 15,
    parameter int OUT_W = 32,
    parameter int SHAMT = 1,
    parameter int LEN_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [LEN_W-1:0] in_len,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_err
);

    localparam logic [1:0] MODE_SIGN  = 2'b00;
    localparam logic [1:0] MODE_ZERO  = 2'b01;
    localparam logic [1:0] MODE_SHIFT = 2'b10;
    localparam logic [1:0] MODE_UPPER = 2'b11;

    typedef struct packed {
        logic             err;
        logic [OUT_W-1:0] data;
    } entry_t;

    // ------------------------------------------------------------------
    // Combinational extension of the incoming request
    // ------------------------------------------------------------------
    logic             len_legal;
    logic [LEN_W-1:0] len_eff;
    logic [OUT_W-1:0] low_mask;    // ones in bits [L-1:0]
    logic             sign_bit;
    logic [OUT_W-1:0] zero_ext;
    logic [OUT_W-1:0] sign_ext;
    logic [OUT_W-1:0] shift_ext;
    logic [OUT_W-1:0] upper_ext;
    int               upper_sh;
    entry_t           new_entry;

    assign len_legal = (in_len != '0) && (in_len <= LEN_W'(IN_W));
    assign len_eff   = len_legal ? in_len : LEN_W'(IN_W);

    always_comb begin
        low_mask = '0;
        sign_bit = 1'b0;
        for (int i = 0; i < OUT_W; i++) begin
            low_mask[i] = (i < int'(len_eff));
        end
        // The sign bit is field bit L-1; pick it without a variable part-select.
        for (int i = 0; i < IN_W; i++) begin
            if (i + 1 == int'(len_eff)) begin
                sign_bit = in_imm[i];
            end
        end
    end

    always_comb begin
        zero_ext  = OUT_W'(in_imm) & low_mask;
        sign_ext  = zero_ext | (sign_bit ? ~low_mask : '0);
        shift_ext = sign_ext << SHAMT;
        upper_sh  = OUT_W - int'(len_eff);
        upper_ext = zero_ext << upper_sh;

        new_entry     = '0;
        new_entry.err = ~len_legal;
        case (in_mode)
            MODE_SIGN:  new_entry.data = sign_ext;
            MODE_ZERO:  new_entry.data = zero_ext;
            MODE_SHIFT: new_entry.data = shift_ext;
            MODE_UPPER: new_entry.data = upper_ext;
            default:    new_entry.data = sign_ext;
        endcase
    end

    // ------------------------------------------------------------------
    // 2-entry output FIFO
    // entry0 is always the head. Slots at or beyond count are kept at zero,
    // which makes out_data/out_err read 0 whenever the buffer is empty.
    // ------------------------------------------------------------------
    entry_t     entry0;
    entry_t     entry1;
    logic [1:0] count;
    logic       push;
    logic       pop;

    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign out_data  = entry0.data;
    assign out_err   = entry0.err;

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry0 <= '0;
            entry1 <= '0;
            count  <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        entry0 <= new_entry;
                    end else begin
                        entry1 <= new_entry;
                    end
                    count <= count + 2'd1;
                end
                2'b01: begin
                    entry0 <= entry1;
                    entry1 <= '0;
                    count  <= count - 2'd1;
                end
                2'b11: begin
                    // Push with pop only happens at count == 1 (count == 2
                    // blocks push, count == 0 blocks pop): replace the head.
                    entry0 <= new_entry;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imm_extend_unit.sv
// ----------------------------------------------------------------------------
// tb_imm_extend_unit
//
// Scoreboard bench for imm_extend_unit (IN_W=15, OUT_W=32, SHAMT=1).
// The driver pushes the expected {err, data} into exp_q when a request is
// accepted; the monitor pops and compares on every output transfer.
// Inputs change 1 time unit after a rising edge; outputs are sampled on the
// falling edge.
// ----------------------------------------------------------------------------
module tb_imm_extend_unit;

    localparam int IN_W  = 15;
    localparam int OUT_W = 32;
    localparam int SHAMT = 1;
    localparam int LEN_W = 5;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_imm;
    logic [LEN_W-1:0] in_len;
    logic [1:0]       in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic             out_err;

    imm_extend_unit #(
        .IN_W (IN_W),
        .OUT_W(OUT_W),
        .SHAMT(SHAMT),
        .LEN_W(LEN_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_imm   (in_imm),
        .in_len   (in_len),
        .in_mode  (in_mode),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_err  (out_err)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    logic [OUT_W:0] exp_q[$];     // {err, data}
    int             out_cyc_q[$]; // cycle of each output transfer
    int             checks = 0;
    int             errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Independent reference: shift-based arithmetic on 32-bit integers.
    function automatic logic [OUT_W:0] model(input logic [IN_W-1:0] imm,
                                             input logic [LEN_W-1:0] len,
                                             input logic [1:0] mode);
        int                 l;
        logic               err;
        logic [31:0]        f;
        logic signed [31:0] t;
        logic [31:0]        r;
        err = (len == 0) || (len > 15);
        l   = err ? 15 : int'(len);
        f   = {17'd0, imm} & ((32'd1 << l) - 32'd1);
        t   = f << (32 - l);
        t   = t >>> (32 - l);
        case (mode)
            2'd0:    r = t;
            2'd1:    r = f;
            2'd2:    r = t << 1;
            default: r = f << (32 - l);
        endcase
        return {err, r};
    endfunction

    // ---------------- driver ----------------
    // Call between a rising edge (+1) and the next falling edge. Returns at
    // rising edge + 1 after acceptance with in_valid dropped.
    task automatic send(input logic [IN_W-1:0] imm, input logic [LEN_W-1:0] len,
                        input logic [1:0] mode, input logic [OUT_W:0] exp);
        logic acc;
        int   n;
        in_valid = 1'b1;
        in_imm   = imm;
        in_len   = len;
        in_mode  = mode;
        n        = 0;
        acc      = 1'b0;
        while (!acc && n < 200) begin
            acc = in_ready;
            if (acc) exp_q.push_back(exp);
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) begin
            errors++;
            checks++;
            $display("FAIL send_timeout: got no accept expected accept within 200 cycles");
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
    endtask

    // ---------------- monitor ----------------
    logic           prev_stall = 1'b0;
    logic [OUT_W:0] prev_word  = '0;

    always @(negedge clk) begin
        logic [OUT_W:0] e;
        if (rst_n) begin
            if (out_valid && prev_stall)
                check("stall_stable", 64'({out_err, out_data}), 64'(prev_word));
            prev_stall = out_valid && !out_ready;
            prev_word  = {out_err, out_data};
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got 0x%0h expected no output", {out_err, out_data});
                end else begin
                    e = exp_q.pop_front();
                    check("out_word", 64'({out_err, out_data}), 64'(e));
                    out_cyc_q.push_back(cyc);
                end
            end
        end else begin
            prev_stall = 1'b0;
        end
    end

    // ---------------- directed vectors ----------------
    typedef struct {
        logic [IN_W-1:0]  imm;
        logic [LEN_W-1:0] len;
        logic [1:0]       mode;
        logic [OUT_W:0]   exp;
    } vec_t;

    vec_t vecs[11];

    initial begin
        vecs[0]  = '{15'h4000, 5'd15, 2'd0, {1'b0, 32'hFFFFC000}};
        vecs[1]  = '{15'h3FFF, 5'd15, 2'd0, {1'b0, 32'h00003FFF}};
        vecs[2]  = '{15'h7F80, 5'd8,  2'd0, {1'b0, 32'hFFFFFF80}};
        vecs[3]  = '{15'h7F80, 5'd8,  2'd1, {1'b0, 32'h00000080}};
        vecs[4]  = '{15'h7FFF, 5'd15, 2'd2, {1'b0, 32'hFFFFFFFE}};
        vecs[5]  = '{15'h0ABC, 5'd12, 2'd3, {1'b0, 32'hABC00000}};
        vecs[6]  = '{15'h0001, 5'd0,  2'd0, {1'b1, 32'h00000001}};
        vecs[7]  = '{15'h0001, 5'd1,  2'd0, {1'b0, 32'hFFFFFFFF}};
        vecs[8]  = '{15'h7FFF, 5'd16, 2'd1, {1'b1, 32'h00007FFF}};
        vecs[9]  = '{15'h0001, 5'd1,  2'd3, {1'b0, 32'h80000000}};
        vecs[10] = '{15'h0080, 5'd8,  2'd2, {1'b0, 32'hFFFFFF00}};
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [IN_W-1:0]  r_imm;
        logic [LEN_W-1:0] r_len;
        logic [1:0]       r_mode;
        logic             c_done;
        int               n;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_imm    = '0;
        in_len    = '0;
        in_mode   = '0;
        out_ready = 1'b1;
        c_done    = 1'b0;

        repeat (3) @(negedge clk);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_in_ready", 64'(in_ready), 64'd1);
        check("reset_out_data", 64'(out_data), 64'd0);
        check("reset_out_err", 64'(out_err), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Directed vectors, one at a time: result visible one edge after accept.
        for (int i = 0; i < 11; i++) begin
            send(vecs[i].imm, vecs[i].len, vecs[i].mode, vecs[i].exp);
            @(negedge clk);
            check("latency_out_valid", 64'(out_valid), 64'd1);
            @(posedge clk);
            #1;
        end
        wait_drain();

        // Stall: A and B fill the buffer, C waits for space.
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        send(15'h0123, 5'd15, 2'd1, {1'b0, 32'h00000123});
        send(15'h0456, 5'd15, 2'd1, {1'b0, 32'h00000456});
        @(negedge clk);
        check("full_in_ready", 64'(in_ready), 64'd0);
        check("full_head", 64'({out_err, out_data}), 64'({1'b0, 32'h00000123}));
        out_cyc_q.delete();
        fork
            begin
                send(15'h0789, 5'd15, 2'd1, {1'b0, 32'h00000789});
                c_done = 1'b1;
            end
        join_none
        repeat (3) @(negedge clk);
        check("stall_in_ready", 64'(in_ready), 64'd0);
        check("stall_queue", 64'(exp_q.size()), 64'd2);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        n = 0;
        while (!c_done && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("stall_c_accepted", 64'(c_done), 64'd1);
        wait_drain();
        check("stall_out_count", 64'(out_cyc_q.size()), 64'd3);
        if (out_cyc_q.size() == 3)
            check("stall_out_span", 64'(out_cyc_q[2] - out_cyc_q[0]), 64'd2);

        // Back-to-back burst of 20 random requests.
        @(posedge clk);
        #1;
        out_cyc_q.delete();
        for (int i = 0; i < 20; i++) begin
            r_imm  = IN_W'($urandom_range(0, 32767));
            r_len  = LEN_W'($urandom_range(0, 17));
            r_mode = 2'($urandom_range(0, 3));
            send(r_imm, r_len, r_mode, model(r_imm, r_len, r_mode));
        end
        wait_drain();
        check("burst_out_count", 64'(out_cyc_q.size()), 64'd20);
        if (out_cyc_q.size() == 20)
            check("burst_out_span", 64'(out_cyc_q[19] - out_cyc_q[0]), 64'd19);

        // Asynchronous reset with two entries buffered.
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        send(15'h0AAA, 5'd15, 2'd1, {1'b0, 32'h00000AAA});
        send(15'h0555, 5'd15, 2'd1, {1'b0, 32'h00000555});
        @(negedge clk);
        check("pre_reset_full", 64'(in_ready), 64'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_out_valid", 64'(out_valid), 64'd0);
        check("async_out_data", 64'(out_data), 64'd0);
        check("async_out_err", 64'(out_err), 64'd0);
        check("async_in_ready", 64'(in_ready), 64'd1);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        check("post_reset_out_valid", 64'(out_valid), 64'd0);
        send(15'h0F00, 5'd12, 2'd0, {1'b0, 32'hFFFFFF00});
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global guard so the run always terminates.
    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish before 200000");
        $fatal(1);
    end

endmodule
